fx_rx_decoder: RTL

- Receive-side PCS for the 100BASE-FX link: the counterpart of the talker transmit path.
- Takes the recovered serial NRZI line bit from the SFP receive input and performs NRZI decode, J/K code-group alignment and 4B/5B decode.
- Delivers MII-style nibbles (rx_dv/rxd/rx_er) plus a frame-end strobe to the downstream frame parser.
- Sits between the clock/data recovery front end and the MAC receive logic.

---
 rtl/fx_rx_decoder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fx_rx_decoder.sv
// 100BASE-FX receive PCS: NRZI decode, J/K alignment and 4B/5B decode to MII-style nibbles.
// Optional FCS checking is built in when FX_RX_FCS_CHECK_EN is defined; otherwise fcs_ok is tied low.
module fx_rx_decoder #(
   parameter int MAX_NIBBLES = 3100,
   parameter int IDLE_BITS   = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bit_in,
   input  logic       bit_vld,
   output logic       rx_dv,
   output logic [3:0] rxd,
   output logic       nib_vld,
   output logic       rx_er,
   output logic       frame_end,
   output logic       link_idle,
   output logic       fcs_ok
);
   localparam int NW = $clog2(MAX_NIBBLES + 1);
   localparam int IW = $clog2(IDLE_BITS + 1);
   localparam logic [4:0] C_J = 5'b11000, C_K = 5'b10001, C_T = 5'b01101,
                          C_R = 5'b00111, C_I = 5'b11111;
   localparam logic [9:0] SSD = {C_J, C_K};

   typedef enum logic {HUNT, FRAME} state_t;

   // Returns {valid, nibble}; valid=0 for control and invalid codes.
   function automatic logic [4:0] dec5(input logic [4:0] g);
      case (g)
         5'b11110: dec5 = {1'b1, 4'h0};
         5'b01001: dec5 = {1'b1, 4'h1};
         5'b10100: dec5 = {1'b1, 4'h2};
         5'b10101: dec5 = {1'b1, 4'h3};
         5'b01010: dec5 = {1'b1, 4'h4};
         5'b01011: dec5 = {1'b1, 4'h5};
         5'b01110: dec5 = {1'b1, 4'h6};
         5'b01111: dec5 = {1'b1, 4'h7};
         5'b10010: dec5 = {1'b1, 4'h8};
         5'b10011: dec5 = {1'b1, 4'h9};
         5'b10110: dec5 = {1'b1, 4'hA};
         5'b10111: dec5 = {1'b1, 4'hB};
         5'b11010: dec5 = {1'b1, 4'hC};
         5'b11011: dec5 = {1'b1, 4'hD};
         5'b11100: dec5 = {1'b1, 4'hE};
         5'b11101: dec5 = {1'b1, 4'hF};
         default:  dec5 = 5'b0_0000;
      endcase
   endfunction

`ifdef FX_RX_FCS_CHECK_EN
   // Residue as an MSB-first value; the reflected register holds its bit reverse.
   localparam logic [31:0] RESIDUE = 32'hC704DD7B;

   function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 4; i++) begin
         if (r[0] ^ n[i]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   function automatic logic [31:0] bitrev32(input logic [31:0] c);
      for (int i = 0; i < 32; i++) bitrev32[i] = c[31-i];
   endfunction

   logic [31:0] crc_q, crc_d;
   logic        sfd_q, sfd_d, last5_q, last5_d, fcs_ok_q, fcs_ok_d;
`endif

   state_t          state_q, state_d;
   logic            prev_q, prev_d;
   // Bit 9 of the 10-bit window is never read, so only 9 bits are stored.
   logic [8:0]      sr_q, sr_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [NW-1:0]   nib_cnt_q, nib_cnt_d;
   logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
   logic            t_seen_q, t_seen_d;
   logic            rx_dv_q, rx_dv_d, nib_vld_q, nib_vld_d, rx_er_q, rx_er_d;
   logic            frame_end_q, frame_end_d, link_idle_q, link_idle_d;
   logic [3:0]      rxd_q, rxd_d;
   logic            dbit, end_frm;
   logic [4:0]      grp, gdec;

   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      nib_cnt_d   = nib_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      t_seen_d    = t_seen_q;
      rx_dv_d     = rx_dv_q;
      rxd_d       = rxd_q;
      link_idle_d = link_idle_q;
      nib_vld_d   = 1'b0;
      rx_er_d     = 1'b0;
      frame_end_d = 1'b0;
      end_frm     = 1'b0;
`ifdef FX_RX_FCS_CHECK_EN
      crc_d    = crc_q;
      sfd_d    = sfd_q;
      last5_d  = last5_q;
      fcs_ok_d = 1'b0;
`endif
      dbit = bit_in ^ prev_q;
      grp  = {sr_q[3:0], dbit};
      gdec = dec5(grp);
      if (bit_vld) begin
         prev_d = bit_in;
         sr_d   = {sr_q[7:0], dbit};
         if (!dbit)                              idle_cnt_d = '0;
         else if (idle_cnt_q != IW'(IDLE_BITS))  idle_cnt_d = idle_cnt_q + 1'b1;
         if (state_q == HUNT) begin
            if ({sr_q, dbit} == SSD) begin
               state_d   = FRAME;
               cnt_d     = '0;
               nib_cnt_d = '0;
               t_seen_d  = 1'b0;
`ifdef FX_RX_FCS_CHECK_EN
               crc_d   = '1;
               sfd_d   = 1'b0;
               last5_d = 1'b0;
`endif
            end
         end else begin
            cnt_d = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
               if (t_seen_q) begin
                  end_frm = 1'b1;
                  rx_er_d = (grp != C_R);
`ifdef FX_RX_FCS_CHECK_EN
                  fcs_ok_d = (grp == C_R) && sfd_q && (bitrev32(crc_q) == RESIDUE);
`endif
               end else if (grp == C_T) begin
                  t_seen_d = 1'b1;
               end else if (grp == C_I || nib_cnt_q == NW'(MAX_NIBBLES)) begin
                  end_frm = 1'b1;
                  rx_er_d = 1'b1;
               end else begin
                  nib_vld_d = 1'b1;
                  rx_dv_d   = 1'b1;
                  nib_cnt_d = nib_cnt_q + 1'b1;
                  if (gdec[4]) begin
                     rxd_d = gdec[3:0];
`ifdef FX_RX_FCS_CHECK_EN
                     if (sfd_q)                             crc_d = crc_nib(crc_q, gdec[3:0]);
                     else if (last5_q && gdec[3:0] == 4'hD) sfd_d = 1'b1;
                     last5_d = (gdec[3:0] == 4'h5);
`endif
                  end else begin
                     rxd_d   = 4'hE;
                     rx_er_d = 1'b1;
`ifdef FX_RX_FCS_CHECK_EN
                     last5_d = 1'b0;
`endif
                  end
               end
            end
         end
         if (end_frm) begin
            state_d     = HUNT;
            rx_dv_d     = 1'b0;
            frame_end_d = 1'b1;
            t_seen_d    = 1'b0;
         end
         link_idle_d = (state_d == HUNT) && (idle_cnt_d == IW'(IDLE_BITS));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         prev_q      <= 1'b0;
         sr_q        <= '0;
         cnt_q       <= '0;
         nib_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         t_seen_q    <= 1'b0;
         rx_dv_q     <= 1'b0;
         rxd_q       <= '0;
         nib_vld_q   <= 1'b0;
         rx_er_q     <= 1'b0;
         frame_end_q <= 1'b0;
         link_idle_q <= 1'b0;
`ifdef FX_RX_FCS_CHECK_EN
         crc_q    <= '1;
         sfd_q    <= 1'b0;
         last5_q  <= 1'b0;
         fcs_ok_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         nib_cnt_q   <= nib_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         t_seen_q    <= t_seen_d;
         rx_dv_q     <= rx_dv_d;
         rxd_q       <= rxd_d;
         nib_vld_q   <= nib_vld_d;
         rx_er_q     <= rx_er_d;
         frame_end_q <= frame_end_d;
         link_idle_q <= link_idle_d;
`ifdef FX_RX_FCS_CHECK_EN
         crc_q    <= crc_d;
         sfd_q    <= sfd_d;
         last5_q  <= last5_d;
         fcs_ok_q <= fcs_ok_d;
`endif
      end
   end

   assign rx_dv     = rx_dv_q;
   assign rxd       = rxd_q;
   assign nib_vld   = nib_vld_q;
   assign rx_er     = rx_er_q;
   assign frame_end = frame_end_q;
   assign link_idle = link_idle_q;
`ifdef FX_RX_FCS_CHECK_EN
   assign fcs_ok = fcs_ok_q;
`else
   assign fcs_ok = 1'b0;
`endif

endmodule
